flash_loader: RTL and testbench

Boot-time image loader that drives the memory's flash port (`flash_addr`, `flash_data`, `flash_en`). It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them to consecutive word addresses starting at 0. While it loads, it holds the memory and CPU in reset, then releases them. It sits between the host byte source (UART receiver or bench) and `memory`.

---
 rtl/flash_loader_pkg.sv | 22 ++
 rtl/flash_loader_byte_packer.sv | 46 ++++
 rtl/flash_loader.sv | 172 +++++++++++++++++
 tb/tb_flash_loader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_loader_pkg.sv
// Shared types and constants for the boot image loader.
// Latency: n/a (package). Backpressure: n/a.
package flash_loader_pkg;

    typedef enum logic [2:0] {
        COUNT = 3'd0,
        DATA  = 3'd1,
        WRITE = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } loader_state_t;

    localparam int LOADER_BASE_ADDR = 0;
    localparam int BYTES_PER_WORD   = 4;

    // States in which a stream byte may be taken from the source.
    function automatic logic is_rx_state(input loader_state_t s);
        return (s == COUNT) || (s == DATA) || (s == CHECK);
    endfunction

endpackage

// File: rtl/flash_loader_byte_packer.sv
// Packs four stream bytes into a little-endian 32-bit word (first byte -> [7:0]).
// Latency: word/word_full reflect the byte pushed this cycle. Backpressure: none, push when ready.
module flash_loader_byte_packer
    import flash_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      shift_q, shift_d;

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clear) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (push) begin
            cnt_d   = cnt_q + CNT_W'(1);
            shift_d = {byte_in, shift_q[31:8]};
        end
    end

    // Look-ahead outputs let the parent register its write in the same edge.
    assign word      = shift_d;
    assign word_full = push && !clear && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/flash_loader.sv
// Boot loader: byte stream (count header + LE words) -> flash writes at 0,4,8..; FLASH_LOADER_CHECKSUM_EN adds trailing XOR byte.
// Latency: flash_en one cycle after a word's 4th byte; 5 cycles/word min. Backpressure: byte_ready low in WRITE/DONE/ERR.
module flash_loader
    import flash_loader_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MAX_WORDS = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic [WIDTH-1:0] flash_addr,
    output logic [WIDTH-1:0] flash_data,
    output logic             flash_en,
    output logic             hold,
    output logic             done,
    output logic             error
);

    localparam int IDX_W = $clog2(MAX_WORDS + 1);

    loader_state_t    state_q, state_d;
    logic [IDX_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             byte_ready_q, byte_ready_d;
    logic             flash_en_q, flash_en_d;
    logic [WIDTH-1:0] flash_addr_q, flash_addr_d;
    logic [WIDTH-1:0] flash_data_q, flash_data_d;
    logic             hold_q, hold_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
`ifdef FLASH_LOADER_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    logic             accept;
    logic             pk_push;
    logic             pk_clear;
    logic [31:0]      pk_word;
    logic             pk_full;
    logic [IDX_W+1:0] byte_off;

    assign accept   = byte_valid && byte_ready_q;
    assign byte_off = {idx_q, 2'b00};

    flash_loader_byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (pk_clear),
        .push      (pk_push),
        .byte_in   (byte_data),
        .word      (pk_word),
        .word_full (pk_full)
    );

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        idx_d        = idx_q;
        flash_en_d   = 1'b0;
        flash_addr_d = flash_addr_q;
        flash_data_d = flash_data_q;
        pk_push      = accept;
        pk_clear     = 1'b0;
`ifdef FLASH_LOADER_CHECKSUM_EN
        csum_d       = csum_q;
        if (accept && (state_q != CHECK)) begin
            csum_d = csum_q ^ byte_data;
        end
`endif

        case (state_q)
            COUNT: begin
                if (pk_full) begin
                    if (pk_word > 32'(MAX_WORDS)) begin
                        state_d = ERR;
                    end else begin
                        count_d = IDX_W'(pk_word);
                        if (pk_word == '0) begin
`ifdef FLASH_LOADER_CHECKSUM_EN
                            state_d = CHECK;
`else
                            state_d = DONE;
`endif
                        end else begin
                            state_d = DATA;
                        end
                    end
                end
            end
            DATA: begin
                if (pk_full) begin
                    state_d      = WRITE;
                    flash_en_d   = 1'b1;
                    flash_addr_d = WIDTH'(LOADER_BASE_ADDR) + WIDTH'(byte_off);
                    flash_data_d = WIDTH'(pk_word);
                end
            end
            WRITE: begin
                idx_d    = idx_q + IDX_W'(1);
                pk_clear = 1'b1;
                if (idx_d == count_q) begin
`ifdef FLASH_LOADER_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = DATA;
                end
            end
`ifdef FLASH_LOADER_CHECKSUM_EN
            CHECK: begin
                // The trailing byte is a comparand, not part of any word.
                pk_push = 1'b0;
                if (accept) begin
                    state_d = (byte_data == csum_q) ? DONE : ERR;
                end
            end
`endif
            default: ;
        endcase

        byte_ready_d = is_rx_state(state_d);
        hold_d       = (state_d != DONE);
        done_d       = (state_d == DONE);
        error_d      = (state_d == ERR);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= COUNT;
            count_q      <= '0;
            idx_q        <= '0;
            byte_ready_q <= 1'b0;
            flash_en_q   <= 1'b0;
            flash_addr_q <= '0;
            flash_data_q <= '0;
            hold_q       <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef FLASH_LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            idx_q        <= idx_d;
            byte_ready_q <= byte_ready_d;
            flash_en_q   <= flash_en_d;
            flash_addr_q <= flash_addr_d;
            flash_data_q <= flash_data_d;
            hold_q       <= hold_d;
            done_q       <= done_d;
            error_q      <= error_d;
`ifdef FLASH_LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign byte_ready = byte_ready_q;
    assign flash_en   = flash_en_q;
    assign flash_addr = flash_addr_q;
    assign flash_data = flash_data_q;
    assign hold       = hold_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_flash_loader.sv
// Randomized bench for flash_loader against a stream-level reference model.
// Honours FLASH_LOADER_CHECKSUM_EN when defined.
module tb_flash_loader;

    localparam int WIDTH     = 32;
    localparam int MAX_WORDS = 1024;
`ifdef FLASH_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             byte_valid = 1'b0;
    logic [7:0]       byte_data = 8'h00;
    logic             byte_ready;
    logic [WIDTH-1:0] flash_addr;
    logic [WIDTH-1:0] flash_data;
    logic             flash_en;
    logic             hold;
    logic             done;
    logic             error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cyc = -1;
    bit done_seen = 1'b0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];
    logic [31:0] words[$];
    int          acc_cyc[$];

    always #5 clk = ~clk;

    flash_loader #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .flash_addr (flash_addr),
        .flash_data (flash_data),
        .flash_en   (flash_en),
        .hold       (hold),
        .done       (done),
        .error      (error)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Observe at the falling edge, well away from the active edge.
    always @(negedge clk) begin
        cyc++;
        if (flash_en) begin
            wr_addr_q.push_back(flash_addr);
            wr_data_q.push_back(flash_data);
            wr_cyc_q.push_back(cyc);
        end
        if (!rst) begin
            done_seen = 1'b0;
        end else if (done && !done_seen) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
    end

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_ready"}, 32'(byte_ready), 32'd0);
        chk({pfx, "_en"},    32'(flash_en),   32'd0);
        chk({pfx, "_addr"},  flash_addr,      32'd0);
        chk({pfx, "_data"},  flash_data,      32'd0);
        chk({pfx, "_hold"},  32'(hold),       32'd1);
        chk({pfx, "_done"},  32'(done),       32'd0);
        chk({pfx, "_error"}, 32'(error),      32'd0);
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        byte_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_first_ready", 32'(byte_ready), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w;
        w          = 0;
        byte_data  = b;
        byte_valid = 1'b1;
        @(negedge clk);
        while (!byte_ready && w < 50) begin
            w++;
            @(negedge clk);
        end
        if (!byte_ready) chk("ready_timeout", 32'(byte_ready), 32'd1);
        @(posedge clk);
        acc_cyc.push_back(cyc);
        #1;
        byte_valid = 1'b0;
    endtask

    // Reference: build the byte stream from the format rules and predict the outcome.
    task automatic run_load(input int n, input int gmin, input int gmax, input bit corrupt);
        logic [7:0]  stream[$];
        logic [7:0]  x;
        logic [31:0] hdr;
        logic [31:0] w;
        int          start;
        int          nexp;
        int          t;
        bit          exp_err;

        hdr = 32'(n);
        x   = 8'h00;
        for (int b = 0; b < 4; b++) stream.push_back(hdr[8*b +: 8]);
        if (n <= MAX_WORDS) begin
            for (int i = 0; i < n; i++) begin
                w = words[i];
                for (int b = 0; b < 4; b++) stream.push_back(w[8*b +: 8]);
            end
        end
        foreach (stream[k]) x ^= stream[k];
        if (CSUM_EN && n <= MAX_WORDS) stream.push_back(corrupt ? (x ^ 8'h03) : x);

        exp_err = (n > MAX_WORDS) || (CSUM_EN && corrupt);
        nexp    = (n > MAX_WORDS) ? 0 : n;
        start   = wr_addr_q.size();
        acc_cyc.delete();

        foreach (stream[k]) begin
            repeat ($urandom_range(gmax, gmin)) begin
                @(posedge clk);
                #1;
            end
            send_byte(stream[k]);
        end

        t = 0;
        while (!(done || error) && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (3) @(posedge clk);
        #1;

        chk("end_done",  32'(done),       32'(!exp_err));
        chk("end_error", 32'(error),      32'(exp_err));
        chk("end_hold",  32'(hold),       32'(exp_err));
        chk("end_ready", 32'(byte_ready), 32'd0);
        chk("wr_count",  32'(wr_addr_q.size() - start), 32'(nexp));
        for (int i = 0; i < nexp; i++) begin
            if (start + i < wr_addr_q.size()) begin
                chk("wr_addr", wr_addr_q[start+i], 32'(4 * i));
                chk("wr_data", wr_data_q[start+i], words[i]);
                chk("wr_lat",  32'(wr_cyc_q[start+i]), 32'(acc_cyc[4 + 4*i + 3] + 1));
            end
        end
        if (!exp_err) begin
            chk("done_lat", 32'(done_cyc - acc_cyc[acc_cyc.size()-1]),
                (n > 0 && !CSUM_EN) ? 32'd2 : 32'd1);
        end
        if (nexp > 0) begin
            chk("addr_hold", flash_addr, 32'(4 * (nexp - 1)));
            chk("data_hold", flash_data, words[nexp-1]);
        end
    endtask

    initial begin
        int start;

        do_reset();

        words.delete();
        words.push_back(32'd12345);
        words.push_back(32'd678910);
        words.push_back(32'hffffffff);
        run_load(3, 0, 0, 1'b0);

        do_reset();
        words.delete();
        run_load(0, 0, 1, 1'b0);

        do_reset();
        run_load(MAX_WORDS + 1, 0, 0, 1'b0);

        do_reset();
        words.delete();
        words.push_back(32'hdeadbeef);
        run_load(1, 1, 1, 1'b0);

        // Abort partway through the first data word.
        do_reset();
        start = wr_addr_q.size();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("mid");
        chk("mid_no_wr", 32'(wr_addr_q.size() - start), 32'd0);
        do_reset();
        words.delete();
        words.push_back($urandom);
        run_load(1, 0, 2, 1'b0);

        do_reset();
        words.delete();
        words.push_back(32'h04030201);
        run_load(1, 0, 0, 1'b0);
        do_reset();
        run_load(1, 0, 0, 1'b1);

        for (int r = 0; r < 8; r++) begin
            int n;
            n = int'($urandom_range(6, 1));
            words.delete();
            for (int i = 0; i < n; i++) words.push_back($urandom);
            do_reset();
            run_load(n, 0, 2, 1'($urandom_range(1, 0)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
